// File: rtl/conv_mem_responder.sv
// Memory-side responder for the convolution engine: image, Layer 0 and Layer 1 stores,
// ready/busy frame handshake, host image load and result readout. Optional CONV_MEM_CHECK_EN adds a sticky err.
`timescale 1ns/1ps
module conv_mem_responder #(
   parameter int IMG_DEPTH = 4096,
   parameter int L1_DEPTH  = 1024,
   parameter int DW        = 20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_valid,
   input  logic [11:0]   ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          ready,
   input  logic          busy,
   input  logic [11:0]   iaddr,
   output logic [DW-1:0] idata,
   input  logic [2:0]    csel,
   input  logic          cwr,
   input  logic [11:0]   caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic          crd,
   input  logic [11:0]   caddr_rd,
   output logic [DW-1:0] cdata_rd,
   output logic          done,
   input  logic          dump_start,
   input  logic          dump_sel,
   output logic          dump_valid,
   output logic [11:0]   dump_addr,
   output logic [DW-1:0] dump_data,
   output logic          dump_last,
`ifdef CONV_MEM_CHECK_EN
   output logic          err,
`endif
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ARM  = 3'd2,
      S_RUN  = 3'd3,
      S_DONE = 3'd4,
      S_DUMP = 3'd5
   } state_t;

   localparam logic [2:0] SEL_L0 = 3'b001;
   localparam logic [2:0] SEL_L1 = 3'b011;

   // Handshakes: ready is held while the frame is armed and drops once busy is seen high; the
   // engine's busy falling ends the frame. Loads and dump words have no back-pressure: ld_valid
   // is taken every cycle it is high in IDLE/LOAD/DONE, dump_valid marks one word per cycle.
   state_t state, next_state;
   logic [DW-1:0] img_mem [IMG_DEPTH];
   logic [DW-1:0] l0_mem  [IMG_DEPTH];
   logic [DW-1:0] l1_mem  [L1_DEPTH];

   logic        img_we, dump_go, layer_en, l0_we, l1_we;
   logic        dump_sel_q;
   logic [11:0] dump_cnt, dump_end;

   assign dbg_state = state;
   assign dump_end  = dump_sel_q ? 12'(L1_DEPTH - 1) : 12'(IMG_DEPTH - 1);
   assign layer_en  = (state == S_ARM) || (state == S_RUN);
   assign l0_we     = layer_en && cwr && (csel == SEL_L0);
   assign l1_we     = layer_en && cwr && (csel == SEL_L1);

   always_comb begin
      next_state = state;
      img_we     = 1'b0;
      dump_go    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (ld_valid) begin
               img_we     = 1'b1;
               next_state = ld_last ? S_ARM : S_LOAD;
            end else if (state == S_DONE && dump_start) begin
               dump_go    = 1'b1;
               next_state = S_DUMP;
            end
         end
         S_LOAD: begin
            if (ld_valid) begin
               img_we = 1'b1;
               if (ld_last) next_state = S_ARM;
            end
         end
         S_ARM:   if (busy) next_state = S_RUN;
         S_RUN:   if (!busy) next_state = S_DONE;
         S_DUMP:  if (dump_cnt == dump_end) next_state = S_DONE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         ready      <= 1'b0;
         done       <= 1'b0;
         dump_sel_q <= 1'b0;
         dump_cnt   <= '0;
         dump_valid <= 1'b0;
         dump_addr  <= '0;
         dump_data  <= '0;
         dump_last  <= 1'b0;
      end else begin
         state      <= next_state;
         ready      <= (next_state == S_ARM);
         done       <= (state == S_RUN) && (next_state == S_DONE);
         dump_valid <= (state == S_DUMP);
         dump_last  <= (state == S_DUMP) && (dump_cnt == dump_end);
         if (dump_go) begin
            dump_sel_q <= dump_sel;
            dump_cnt   <= '0;
         end else if (state == S_DUMP) begin
            dump_cnt  <= dump_cnt + 12'd1;
            dump_addr <= dump_cnt;
            dump_data <= dump_sel_q ? l1_mem[dump_cnt[9:0]] : l0_mem[dump_cnt];
         end
      end
   end

   // Arrays carry no reset so their contents survive reset and later frames.
   always_ff @(posedge clk) begin
      if (img_we) img_mem[ld_addr] <= ld_data;
      if (l0_we)  l0_mem[caddr_wr] <= cdata_wr;
      if (l1_we)  l1_mem[caddr_wr[9:0]] <= cdata_wr;
   end

   assign idata = img_mem[iaddr];

   always_comb begin
      cdata_rd = '0;
      if (crd && csel == SEL_L0)      cdata_rd = l0_mem[caddr_rd];
      else if (crd && csel == SEL_L1) cdata_rd = l1_mem[caddr_rd[9:0]];
   end

`ifdef CONV_MEM_CHECK_EN
   logic err_hit;
   assign err_hit = (cwr && csel != SEL_L0 && csel != SEL_L1)
                 || (cwr && !layer_en)
                 || (csel == SEL_L1 && ((cwr && |caddr_wr[11:10]) || (crd && |caddr_rd[11:10])))
                 || (cwr && crd && caddr_wr == caddr_rd);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       err <= 1'b0;
      else if (err_hit) err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_conv_mem_responder.sv
// Self-checking bench for conv_mem_responder: load, layer access, done pulse, scoreboarded L1 readout,
// reset during readout and retention; err checks when CONV_MEM_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_conv_mem_responder;
   localparam int DW = 20;
   localparam int W  = 33;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_ARM = 3'd2,
                          ST_RUN = 3'd3, ST_DONE = 3'd4, ST_DUMP = 3'd5;

   logic          clk = 1'b0, reset = 1'b0;
   logic          ld_valid = 1'b0, ld_last = 1'b0, busy = 1'b0;
   logic [11:0]   ld_addr = '0, iaddr = '0, caddr_wr = '0, caddr_rd = '0;
   logic [DW-1:0] ld_data = '0, cdata_wr = '0;
   logic [2:0]    csel = '0;
   logic          cwr = 1'b0, crd = 1'b0, dump_start = 1'b0, dump_sel = 1'b0;
   logic          ready, done, dump_valid, dump_last;
   logic [DW-1:0] idata, cdata_rd, dump_data;
   logic [11:0]   dump_addr;
   logic [2:0]    dbg_state;
`ifdef CONV_MEM_CHECK_EN
   logic          err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0]  exp_q[$];
   logic [DW-1:0] l1_m [1024];

   conv_mem_responder dut (
      .clk(clk), .reset(reset),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
      .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
      .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .done(done),
      .dump_start(dump_start), .dump_sel(dump_sel), .dump_valid(dump_valid),
      .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last),
`ifdef CONV_MEM_CHECK_EN
      .err(err),
`endif
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #1_000_000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0]  got_w, exp_w;
      logic [DW-1:0] d;
      int seen, gaps, found;
      logic started;

      // reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", ready, 0);
      check("rst_done", done, 0);
      check("rst_dump_valid", dump_valid, 0);
      check("rst_dump_addr", dump_addr, 0);
      check("rst_dump_data", dump_data, 0);
      check("rst_dump_last", dump_last, 0);
      check("rst_state", dbg_state, ST_IDLE);
      @(negedge clk) reset = 1'b1;

      // image load img[a] = a
      for (int a = 0; a < 4096; a++) begin
         @(negedge clk);
         ld_valid = 1'b1; ld_addr = 12'(a); ld_data = DW'(a); ld_last = (a == 4095);
         if (a == 4095) begin
            #1;
            check("ready_before_last", ready, 0);
            check("state_load", dbg_state, ST_LOAD);
         end
      end
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0; iaddr = 12'h123;
      #1;
      check("ready_after_last", ready, 1);
      check("state_arm", dbg_state, ST_ARM);
      check("idata_123", idata, 20'h00123);
      iaddr = 12'hFFF; #1;
      check("idata_fff", idata, 20'h00FFF);

      // L0 writes in ARM, then busy
      @(negedge clk);
      csel = 3'b001; cwr = 1'b1; caddr_wr = 12'd7; cdata_wr = 20'h00777;
      @(negedge clk);
      busy = 1'b1; caddr_wr = 12'd5; cdata_wr = 20'h11111;
      #1 check("ready_hold_arm", ready, 1);
      @(negedge clk);
      cdata_wr = 20'hABCDE; crd = 1'b1; caddr_rd = 12'd5;
      #1;
      check("ready_drop", ready, 0);
      check("state_run", dbg_state, ST_RUN);
      check("rw_same_cycle_old", cdata_rd, 20'h11111);
      @(negedge clk);
      cwr = 1'b0;
      #1 check("rw_next_cycle_new", cdata_rd, 20'hABCDE);
      caddr_rd = 12'd7;
      #1 check("l0_7", cdata_rd, 20'h00777);

      // ld_valid ignored in RUN
      @(negedge clk);
      crd = 1'b0; ld_valid = 1'b1; ld_addr = 12'h010; ld_data = 20'hFFFFF; ld_last = 1'b1;
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0; iaddr = 12'h010;
      #1;
      check("ld_ignored_run", idata, 20'h00010);
      check("state_run_after_ld", dbg_state, ST_RUN);

      // fill L1
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         d = (i == 1023) ? 20'h00042 : DW'($urandom_range(0, 20'hFFFFF));
         l1_m[i] = d;
         csel = 3'b011; cwr = 1'b1; caddr_wr = 12'(i); cdata_wr = d;
      end
      @(negedge clk);
      cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd1023;
      #1 check("l1_1023", cdata_rd, 20'h00042);
      for (int k = 0; k < 4; k++) begin
         caddr_rd = 12'($urandom_range(0, 1022));
         #1 check("l1_rand", cdata_rd, l1_m[caddr_rd[9:0]]);
      end
      csel = 3'b000; caddr_rd = 12'd5;
      #1 check("rd_csel000", cdata_rd, 0);
      csel = 3'b010;
      #1 check("rd_csel010", cdata_rd, 0);

      // write with illegal csel is dropped
      @(negedge clk);
      crd = 1'b0; csel = 3'b010; cwr = 1'b1; caddr_wr = 12'd7; cdata_wr = 20'hBAD00;
      @(negedge clk);
      cwr = 1'b0; crd = 1'b1; csel = 3'b001; caddr_rd = 12'd7;
      #1 check("bad_csel_l0", cdata_rd, 20'h00777);
      csel = 3'b011;
      #1 check("bad_csel_l1", cdata_rd, l1_m[7]);

      // end of frame
      @(negedge clk);
      crd = 1'b0; busy = 1'b0;
      #1 check("done_pre", done, 0);
      @(negedge clk);
      #1;
      check("done_pulse", done, 1);
      check("state_done", dbg_state, ST_DONE);
      @(negedge clk);
      #1 check("done_single", done, 0);

      // write outside ARM/RUN dropped
      @(negedge clk);
      csel = 3'b001; cwr = 1'b1; caddr_wr = 12'd5; cdata_wr = 20'h55555;
      @(negedge clk);
      cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd5;
      #1 check("wr_in_done_dropped", cdata_rd, 20'hABCDE);

      // L1 readout against scoreboard
      @(negedge clk);
      crd = 1'b0; dump_start = 1'b1; dump_sel = 1'b1;
      for (int i = 0; i < 1024; i++) exp_q.push_back({i == 1023, 12'(i), l1_m[i]});
      @(negedge clk);
      dump_start = 1'b0;
      #1;
      check("dump_latency", dump_valid, 0);
      check("state_dump", dbg_state, ST_DUMP);
      seen = 0; gaps = 0; started = 1'b0;
      for (int c = 0; c < 1200 && seen < 1024; c++) begin
         @(negedge clk);
         #1;
         if (dump_valid) begin
            started = 1'b1;
            got_w = {dump_last, dump_addr, dump_data};
            if (exp_q.size() == 0) check("dump_extra", got_w, 0);
            else begin
               exp_w = exp_q.pop_front();
               check("dump_word", got_w, exp_w);
            end
            seen++;
         end else if (started) gaps++;
      end
      check("dump_count", seen, 1024);
      check("dump_gaps", gaps, 0);
      check("dump_q_empty", exp_q.size(), 0);
      @(negedge clk);
      #1;
      check("dump_end_valid", dump_valid, 0);
      check("dump_end_state", dbg_state, ST_DONE);

      // L0 readout aborted by reset at word 300
      @(negedge clk);
      dump_start = 1'b1; dump_sel = 1'b0;
      @(negedge clk);
      dump_start = 1'b0;
      found = 0;
      for (int c = 0; c < 400 && found == 0; c++) begin
         @(negedge clk);
         #1;
         if (dump_valid && dump_addr == 12'd5) check("dump_l0_5", dump_data, 20'hABCDE);
         if (dump_valid && dump_addr == 12'd300) found = 1;
      end
      check("dump_reached_300", found, 1);
      reset = 1'b0;
      #1;
      check("abort_valid", dump_valid, 0);
      check("abort_addr", dump_addr, 0);
      check("abort_data", dump_data, 0);
      check("abort_last", dump_last, 0);
      check("abort_state", dbg_state, ST_IDLE);
      check("abort_ready", ready, 0);
      @(negedge clk) reset = 1'b1;

      // fresh single-word frame, retention
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 12'd0; ld_data = 20'hAAAAA; ld_last = 1'b1;
      #1 check("state_idle_ld", dbg_state, ST_IDLE);
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0; iaddr = 12'd0;
      #1;
      check("ready_single", ready, 1);
      check("idata_0_new", idata, 20'hAAAAA);
      iaddr = 12'h123;
      #1 check("idata_retained", idata, 20'h00123);
`ifdef CONV_MEM_CHECK_EN
      check("err_clear", err, 0);
`endif
      @(negedge clk) busy = 1'b1;
      @(negedge clk);
      crd = 1'b1; csel = 3'b001; caddr_rd = 12'd5;
      #1;
      check("state_run2", dbg_state, ST_RUN);
      check("l0_retained", cdata_rd, 20'hABCDE);
      csel = 3'b011; caddr_rd = 12'd1023;
      #1 check("l1_retained", cdata_rd, 20'h00042);
      caddr_rd = 12'd300;
      #1 check("l1_300_retained", cdata_rd, l1_m[300]);
`ifdef CONV_MEM_CHECK_EN
      @(negedge clk);
      crd = 1'b0; cwr = 1'b1; csel = 3'b010; caddr_wr = 12'd5; cdata_wr = 20'h12345;
      @(negedge clk);
      cwr = 1'b0; crd = 1'b1; csel = 3'b001; caddr_rd = 12'd5;
      #1;
      check("err_set", err, 1);
      check("err_l0_kept", cdata_rd, 20'hABCDE);
      csel = 3'b011;
      #1 check("err_l1_kept", cdata_rd, l1_m[5]);
      repeat (3) @(negedge clk);
      #1 check("err_sticky", err, 1);
`endif
      @(negedge clk);
      crd = 1'b0; busy = 1'b0;
      @(negedge clk);
      #1 check("done_pulse2", done, 1);
`ifdef CONV_MEM_CHECK_EN
      reset = 1'b0;
      #1 check("err_reset", err, 0);
      @(negedge clk) reset = 1'b1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
